// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg: shared pipeline-entry type and forward-select encodings
package forwarding_unit_pkg;
    localparam int DEPTH_DEF = 3;
    localparam int RD_MAX_W = 8;
    localparam int STG_MAX_W = 4;
    localparam int FWD_RF = 0;
    localparam int FWD_EX = 1;
    localparam int FWD_MEM = 2;
    localparam int FWD_WB = 3;
    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [RD_MAX_W-1:0]  rd;
        logic [STG_MAX_W-1:0] ready_stage;
    } fwd_entry_t;
endpackage

// File: rtl/forwarding_scoreboard_fwd_match.sv
// fwd_match: youngest-producer lookup for one source register port
module fwd_match
    import forwarding_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int REG_W = 5,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  fwd_entry_t [DEPTH-1:0] i_entries,
    input  logic [REG_W-1:0]       i_rs,
    input  logic                   i_rs_valid,
    output logic [SEL_W-1:0]       o_fwd_sel,
    output logic                   o_stall_req
);
    // scan oldest to youngest so the youngest hit overrides; a result not yet produced stalls instead of forwarding
    always_comb begin
        o_fwd_sel = SEL_W'(FWD_RF);
        o_stall_req = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_rs_valid && i_entries[i].valid && i_entries[i].we && i_entries[i].rd != '0 &&
                i_entries[i].rd == RD_MAX_W'(i_rs)) begin
                o_stall_req = i_entries[i].ready_stage > STG_MAX_W'(i);
                o_fwd_sel = o_stall_req ? SEL_W'(FWD_RF) : SEL_W'(i + 1);
            end
        end
    end
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: pipeline hazard tracker with forwarding select and load-use stall; FWD_LONG_OP_EN adds a long-op busy interlock
module forwarding_scoreboard
    import forwarding_unit_pkg::*;
#(
    parameter int NUM_RS = 2,
    parameter int DEPTH = DEPTH_DEF,
    parameter int REG_W = 5,
    localparam int STG_W = $clog2(DEPTH),
    localparam int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_issue_valid,
    input  logic [REG_W-1:0]             i_issue_rd,
    input  logic                         i_issue_we,
    input  logic [STG_W-1:0]             i_issue_ready_stage,
    input  logic                         i_hold,
    input  logic                         i_flush,
`ifdef FWD_LONG_OP_EN
    input  logic                         i_long_start,
    input  logic [REG_W-1:0]             i_long_rd,
    input  logic                         i_long_done,
`endif
    input  logic [NUM_RS-1:0][REG_W-1:0] i_rs,
    input  logic [NUM_RS-1:0]            i_rs_valid,
    output logic [NUM_RS-1:0][SEL_W-1:0] o_fwd_sel,
    output logic                         o_stall,
    output logic [31:0]                  o_stall_count
);
    fwd_entry_t [DEPTH-1:0] r_entries;
    fwd_entry_t             w_issue;
    logic [NUM_RS-1:0]      w_stall_req;
    logic                   w_long_stall;
    logic [31:0]            r_stall_count;
    assign w_issue = '{valid: 1'b1, we: i_issue_we, rd: RD_MAX_W'(i_issue_rd),
                       ready_stage: STG_MAX_W'(i_issue_ready_stage)};
    for (genvar p = 0; p < NUM_RS; p++) begin : g_match
        fwd_match #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) u_match (
            .i_entries   (r_entries),
            .i_rs        (i_rs[p]),
            .i_rs_valid  (i_rs_valid[p]),
            .o_fwd_sel   (o_fwd_sel[p]),
            .o_stall_req (w_stall_req[p])
        );
    end
`ifdef FWD_LONG_OP_EN
    logic              r_busy;
    logic [REG_W-1:0]  r_busy_rd;
    logic [NUM_RS-1:0] w_busy_hit;
    for (genvar p = 0; p < NUM_RS; p++) begin : g_busy
        assign w_busy_hit[p] = i_rs_valid[p] && i_rs[p] == r_busy_rd && r_busy_rd != '0;
    end
    assign w_long_stall = r_busy && (|w_busy_hit || i_long_start);
    // a new long op takes priority over a completing one so back-to-back ops stay tracked
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_busy_rd <= '0;
        end else if (i_long_start) begin
            r_busy <= 1'b1;
            r_busy_rd <= i_long_rd;
        end else if (i_long_done) begin
            r_busy <= 1'b0;
        end
    end
`else
    assign w_long_stall = 1'b0;
`endif
    assign o_stall = !i_flush && (|w_stall_req || w_long_stall);
    assign o_stall_count = r_stall_count;
    // advance the tracked stages and admit the issuing instruction into Execute, or a bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_entries <= '0;
        end else if (!i_hold) begin
            for (int i = DEPTH - 1; i > 0; i--) r_entries[i] <= r_entries[i - 1];
            r_entries[0] <= (i_issue_valid && !o_stall && !i_flush) ? w_issue : '0;
        end else if (i_flush) begin
            r_entries[0] <= '0;
        end
    end
    // saturating count of stalled cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_stall_count <= '0;
        else if (o_stall && r_stall_count != '1) r_stall_count <= r_stall_count + 32'd1;
    end
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb_forwarding_scoreboard: directed scoreboard bench for forwarding_scoreboard
module tb_forwarding_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic issue_valid, issue_we, hold, flush;
    logic [4:0] issue_rd;
    logic [1:0] issue_stage;
    logic [1:0][4:0] rs;
    logic [1:0] rs_valid;
    logic [1:0][1:0] fwd_sel;
    logic stall;
    logic [31:0] stall_count;
`ifdef FWD_LONG_OP_EN
    logic long_start, long_done;
    logic [4:0] long_rd;
`endif
    typedef struct {
        string       name;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic        st;
        logic [31:0] cnt;
    } exp_t;
    exp_t q[$];
    logic chk = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forwarding_scoreboard dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_issue_valid       (issue_valid),
        .i_issue_rd          (issue_rd),
        .i_issue_we          (issue_we),
        .i_issue_ready_stage (issue_stage),
        .i_hold              (hold),
        .i_flush             (flush),
`ifdef FWD_LONG_OP_EN
        .i_long_start        (long_start),
        .i_long_rd           (long_rd),
        .i_long_done         (long_done),
`endif
        .i_rs                (rs),
        .i_rs_valid          (rs_valid),
        .o_fwd_sel           (fwd_sel),
        .o_stall             (stall),
        .o_stall_count       (stall_count)
    );

    task automatic cmp(input string n, input string f, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s.%s got %0h want %0h", n, f, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            exp_t e;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor got output with empty expectation queue");
            end else begin
                e = q.pop_front();
                cmp(e.name, "fwd0", 32'(fwd_sel[0]), 32'(e.f0));
                cmp(e.name, "fwd1", 32'(fwd_sel[1]), 32'(e.f1));
                cmp(e.name, "stall", 32'(stall), 32'(e.st));
                cmp(e.name, "count", stall_count, e.cnt);
            end
        end
    end

    task automatic want(input string n, input logic [1:0] f0, input logic [1:0] f1, input logic st, input logic [31:0] c);
        exp_t e;
        e.name = n;
        e.f0 = f0;
        e.f1 = f1;
        e.st = st;
        e.cnt = c;
        q.push_back(e);
        chk = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic iss(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] stg);
        issue_valid = v;
        issue_rd = rd;
        issue_we = we;
        issue_stage = stg;
    endtask

    task automatic src(input logic [4:0] r0, input logic v0, input logic [4:0] r1, input logic v1);
        rs[0] = r0;
        rs_valid[0] = v0;
        rs[1] = r1;
        rs_valid[1] = v1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        iss(0, 0, 0, 0);
        src(0, 0, 0, 0);
        hold = 1'b0;
        flush = 1'b0;
`ifdef FWD_LONG_OP_EN
        long_start = 1'b0;
        long_done = 1'b0;
        long_rd = '0;
`endif
        @(posedge clk);
        #1;
        src(5, 1, 0, 0);
        want("reset", 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        iss(1, 5, 1, 0); src(0, 0, 0, 0);
        want("idle", 0, 0, 0, 0); tick();
        iss(0, 0, 0, 0); src(5, 1, 0, 0);
        want("alu_ex", 1, 0, 0, 0); tick();
        want("alu_mem", 2, 0, 0, 0); tick();
        want("alu_wb", 3, 0, 0, 0); tick();
        iss(1, 7, 1, 1);
        want("aged_out", 0, 0, 0, 0); tick();
        iss(1, 8, 1, 0); src(0, 0, 7, 1);
        want("load_use", 0, 0, 1, 0); tick();
        want("load_fwd", 0, 2, 0, 1); tick();
        iss(1, 3, 1, 0); src(8, 1, 7, 1);
        want("two_ports", 1, 3, 0, 1); tick();
        src(3, 1, 8, 1);
        want("rd3_ex", 1, 2, 0, 1); tick();
        iss(1, 0, 1, 1);
        want("youngest", 1, 3, 0, 1); tick();
        iss(1, 4, 0, 1); src(0, 1, 0, 1);
        want("x0", 0, 0, 0, 1); tick();
        iss(1, 9, 1, 0); src(4, 1, 3, 1);
        want("we0", 0, 3, 0, 1); tick();
        iss(0, 0, 0, 0); src(9, 1, 0, 0); hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            want("hold", 1, 0, 0, 1); tick();
        end
        flush = 1'b1;
        want("flush_pre", 1, 0, 0, 1); tick();
        hold = 1'b0; flush = 1'b0; iss(1, 10, 1, 1);
        want("flushed", 0, 0, 0, 1); tick();
        iss(0, 0, 0, 0); src(10, 1, 0, 0); flush = 1'b1;
        want("flush_nostall", 0, 0, 0, 1); tick();
        flush = 1'b0; iss(1, 11, 1, 1);
        want("post_flush_fwd", 2, 0, 0, 1); tick();
        iss(0, 0, 0, 0); src(11, 1, 0, 0);
        want("stall2", 0, 0, 1, 1); tick();
        iss(1, 11, 1, 1);
        want("stall2_fwd", 2, 0, 0, 2); tick();
        iss(0, 0, 0, 0); rst_n = 1'b0;
        want("async_rst", 0, 0, 0, 0); tick();
        rst_n = 1'b1; iss(1, 6, 1, 0);
        want("post_rst", 0, 0, 0, 0); tick();
        iss(0, 0, 0, 0); src(6, 1, 11, 1);
        want("post_rst_issue", 1, 0, 0, 0); tick();
`ifdef FWD_LONG_OP_EN
        src(0, 0, 0, 0); long_rd = 5'd12; long_start = 1'b1;
        want("long_start", 0, 0, 0, 0); tick();
        long_start = 1'b0; src(12, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            want("long_busy", 0, 0, 1, 32'(k)); tick();
        end
        long_done = 1'b1;
        want("long_done_cyc", 0, 0, 1, 10); tick();
        long_done = 1'b0;
        want("long_clear", 0, 0, 0, 11); tick();
        long_start = 1'b1; src(0, 0, 0, 0);
        want("long_restart", 0, 0, 0, 11); tick();
        src(12, 1, 0, 0);
        want("long_again", 0, 0, 1, 11); tick();
        long_start = 1'b0; rst_n = 1'b0;
        want("long_rst", 0, 0, 0, 0); tick();
        rst_n = 1'b1;
        want("long_after_rst", 0, 0, 0, 0); tick();
`endif
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
